// File: rtl/gamepad_reader_if.sv
// Pad pins and debounced button outputs of the NES-style gamepad reader.
interface gamepad_reader_if;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] buttons;
    logic       btn_reset;
    logic       btn_mode;
    logic       btn_step;
    logic       frame_done;

    modport master (
        input  pad_data,
        output pad_latch, pad_clk, buttons,
        output btn_reset, btn_mode, btn_step, frame_done
    );

    modport slave (
        output pad_data,
        input  pad_latch, pad_clk, buttons,
        input  btn_reset, btn_mode, btn_step, frame_done
    );
endinterface

// File: rtl/gamepad_reader.sv
// Polls a serial gamepad, debounces whole frames, emits 1-cycle press strobes.
module gamepad_reader #(
    parameter int CLK_DIV        = 300,
    parameter int POLL_PERIOD    = 833333,
    parameter int DEBOUNCE_POLLS = 3
) (
    input  logic             clock,
    input  logic             reset,
    gamepad_reader_if.master pad
);
    localparam int TMAX = (POLL_PERIOD > 2 * CLK_DIV) ? POLL_PERIOD : 2 * CLK_DIV;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int SW   = (DEBOUNCE_POLLS > 1) ? $clog2(DEBOUNCE_POLLS) : 1;

    localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] LATCH_LAST = TW'(2 * CLK_DIV - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(CLK_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_POLLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    sync_q, sync_d;
    logic [7:0]    raw_q, raw_d;
    logic [7:0]    prev_q, prev_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [7:0]    buttons_q, buttons_d;
    logic [2:0]    pulse_q, pulse_d;
    logic          frame_done_q, frame_done_d;
    logic          pad_latch_q, pad_latch_d;
    logic          pad_clk_q, pad_clk_d;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + TW'(1);
        bit_d        = bit_q;
        sync_d       = {sync_q[0], pad.pad_data};
        raw_d        = raw_q;
        prev_d       = prev_q;
        stable_d     = stable_q;
        buttons_d    = buttons_q;
        pulse_d      = '0;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (timer_q == POLL_LAST) begin
                    state_d = LATCH;
                    timer_d = '0;
                end
            end
            LATCH: begin
                if (timer_q == LATCH_LAST) begin
                    state_d = LOW;
                    timer_d = '0;
                    bit_d   = '0;
                end
            end
            LOW: begin
                // Pad data is active-low; store pressed as 1.
                if (timer_q == HALF_LAST) begin
                    raw_d[bit_q] = ~sync_q[1];
                    state_d      = HIGH;
                    timer_d      = '0;
                end
            end
            HIGH: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = DONE;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = LOW;
                    end
                end
            end
            DONE: begin
                state_d      = IDLE;
                timer_d      = '0;
                prev_d       = raw_q;
                frame_done_d = 1'b1;
                if (raw_q == prev_q) begin
                    if (stable_q != STABLE_MAX) begin
                        stable_d = stable_q + SW'(1);
                    end
                end else begin
                    stable_d = '0;
                end
                if (stable_d == STABLE_MAX) begin
                    buttons_d = raw_q;
                    pulse_d   = {raw_q[3] & ~buttons_q[3],
                                 raw_q[2] & ~buttons_q[2],
                                 raw_q[0] & ~buttons_q[0]};
                end
            end
            default: state_d = IDLE;
        endcase
        pad_latch_d = (state_d == LATCH);
        pad_clk_d   = (state_d != LOW);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_q        <= '0;
            sync_q       <= 2'b11;
            raw_q        <= '0;
            prev_q       <= '0;
            stable_q     <= '0;
            buttons_q    <= '0;
            pulse_q      <= '0;
            frame_done_q <= 1'b0;
            pad_latch_q  <= 1'b0;
            pad_clk_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_q        <= bit_d;
            sync_q       <= sync_d;
            raw_q        <= raw_d;
            prev_q       <= prev_d;
            stable_q     <= stable_d;
            buttons_q    <= buttons_d;
            pulse_q      <= pulse_d;
            frame_done_q <= frame_done_d;
            pad_latch_q  <= pad_latch_d;
            pad_clk_q    <= pad_clk_d;
        end
    end

    assign pad.pad_latch  = pad_latch_q;
    assign pad.pad_clk    = pad_clk_q;
    assign pad.buttons    = buttons_q;
    assign pad.btn_reset  = pulse_q[2];
    assign pad.btn_mode   = pulse_q[1];
    assign pad.btn_step   = pulse_q[0];
    assign pad.frame_done = frame_done_q;
endmodule

// File: tb/tb_gamepad_reader.sv
// Bench for gamepad_reader: frame-level reference model, pad model, scoreboard.
module tb_gamepad_reader;
    localparam int CD = 2;
    localparam int PP = 10;
    localparam int DP = 2;
    localparam int FR = PP + 18 * CD + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    gamepad_reader_if gp ();

    gamepad_reader #(
        .CLK_DIV       (CD),
        .POLL_PERIOD   (PP),
        .DEBOUNCE_POLLS(DP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pad  (gp.master)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    // Raw pattern (1=pressed) presented by the pad model, one per latched frame.
    logic [7:0] pat [24];
    initial begin
        for (int i = 0; i < 24; i++) pat[i] = 8'h00;
        pat[2]  = 8'h08; pat[3]  = 8'h08; pat[4]  = 8'h08;
        pat[7]  = 8'h0D; pat[8]  = 8'h0D;
        pat[11] = 8'h01; pat[13] = 8'h01;
        pat[15] = 8'h80; pat[16] = 8'h80; pat[17] = 8'h90;
    end

    // Reference model: cycle k since reset release, frame period FR.
    int         k = 0;
    int         pi = 0;
    int         m_run;
    logic [7:0] cur = 8'h00;
    logic [7:0] fr_raw, m_prev, m_btn;
    logic       e_latch, e_pclk, e_fd;
    logic [2:0] e_pul;

    always @(posedge clock or negedge reset) begin
        int m;
        if (!reset) begin
            k = 0; m_run = 1; m_prev = 0; m_btn = 0;
            e_latch = 0; e_pclk = 1; e_fd = 0; e_pul = 0;
        end else begin
            k++;
            m = k % FR;
            e_latch = (m >= PP) && (m < PP + 2 * CD);
            e_pclk  = !((m >= PP + 2 * CD) && (m < FR - 1) &&
                        (((m - PP - 2 * CD) / CD) % 2 == 0));
            if (m == PP) begin
                cur = (pi < 24) ? pat[pi] : 8'h00;
                fr_raw = cur;
                pi++;
            end
            e_fd = 0; e_pul = 0;
            if (m == 0) begin
                e_fd = 1;
                m_run = (fr_raw == m_prev) ? m_run + 1 : 1;
                m_prev = fr_raw;
                if (m_run >= DP) begin
                    e_pul = {fr_raw[3] & ~m_btn[3], fr_raw[2] & ~m_btn[2],
                             fr_raw[0] & ~m_btn[0]};
                    m_btn = fr_raw;
                end
            end
        end
    end

    // Pad: shift register loaded on latch, advanced on pad_clk rising edge.
    logic [7:0] sh = 8'h00;
    logic       pad_pclk = 1'b1;
    initial gp.pad_data = 1'b1;
    always @(negedge clock) begin
        if (gp.pad_latch) sh = cur;
        else if (gp.pad_clk && !pad_pclk) sh = sh >> 1;
        pad_pclk = gp.pad_clk;
        gp.pad_data = ~sh[0];
    end

    // Per-cycle compare plus scoreboard.
    int         rises = 0;
    int         n_rst = 0, n_mode = 0, n_step = 0;
    logic       p_lat = 1'b0, p_clk = 1'b1;
    logic [2:0] p_pul = 3'b000;
    always @(negedge clock) begin
        logic [2:0] pul;
        pul = {gp.btn_reset, gp.btn_mode, gp.btn_step};
        if (!reset) begin
            rises = 0;
        end else begin
            chk("pad_latch", gp.pad_latch, e_latch);
            chk("pad_clk", gp.pad_clk, e_pclk);
            chk("frame_done", gp.frame_done, e_fd);
            chk("buttons", gp.buttons, m_btn);
            chk("pulses", pul, e_pul);
            chk("pulse_w", pul & p_pul, 0);
            chk("lat_clk_rise", (gp.pad_latch & ~p_lat) & (gp.pad_clk & ~p_clk), 0);
            if (gp.pad_clk && !p_clk) rises++;
            if (e_fd) begin
                chk("rises", rises, 8);
                rises = 0;
            end
            n_rst  += int'(gp.btn_reset);
            n_mode += int'(gp.btn_mode);
            n_step += int'(gp.btn_step);
        end
        p_lat = gp.pad_latch;
        p_clk = gp.pad_clk;
        p_pul = pul;
    end

    task automatic wait_k(input int tgt);
        int n;
        n = 0;
        while (k < tgt && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("wait_k", k, tgt);
    endtask

    task automatic latch_delay();
        int n;
        n = 0;
        while (!gp.pad_latch && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("latch_delay", n, PP);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_pclk", gp.pad_clk, 1);
        chk("rst_latch", gp.pad_latch, 0);
        chk("rst_buttons", gp.buttons, 8'h00);
        chk("rst_fd", gp.frame_done, 0);
        reset = 1'b1;
        latch_delay();
        wait_k(FR);
        chk("fd_first", gp.frame_done, 1);
        wait_k(4 * FR);
        chk("start_btn", gp.buttons, 8'h08);
        chk("start_pulse", gp.btn_reset, 1);
        wait_k(4 * FR + 1);
        chk("start_pulse_end", gp.btn_reset, 0);
        wait_k(5 * FR);
        chk("start_held", gp.btn_reset, 0);
        wait_k(9 * FR);
        chk("combo_btn", gp.buttons, 8'h0D);
        chk("combo_pul", {gp.btn_reset, gp.btn_mode, gp.btn_step}, 3'b111);
        wait_k(15 * FR + 1);
        chk("alt_btn", gp.buttons, 8'h00);
        chk("alt_steps", n_step, 1);
        wait_k(17 * FR + 1);
        chk("right_btn", gp.buttons, 8'h80);
        wait_k(17 * FR + PP + 4 * CD + 4 * 2 * CD + CD);
        chk("mid_pclk_high", gp.pad_clk, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_latch", gp.pad_latch, 0);
        chk("abort_pclk", gp.pad_clk, 1);
        chk("abort_buttons", gp.buttons, 8'h00);
        chk("abort_fd", gp.frame_done, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        latch_delay();
        wait_k(2 * FR + 1);
        chk("post_btn", gp.buttons, 8'h00);
        chk("cnt_reset", n_rst, 2);
        chk("cnt_mode", n_mode, 1);
        chk("cnt_step", n_step, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
